// File: rtl/hart_sequencer.sv
// Multi-cycle control sequencer for an RV32I hart: fetch, decode, execute, memory, writeback.
// Owns PC, instruction register, register-file write strobe, writeback select and retire/halt status.
module hart_sequencer #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic [ILEN-1:0] instr_bits,
    input  logic [6:0]      opcode,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] target_pc,
    output logic            dmem_req_valid,
    output logic            dmem_req_we,
    input  logic            dmem_req_ready,
    input  logic            dmem_resp_valid,
    output logic            rf_we,
    output logic [1:0]      wb_sel,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            halted
);

    localparam logic [2:0] FETCH_REQ  = 3'd0;
    localparam logic [2:0] FETCH_WAIT = 3'd1;
    localparam logic [2:0] DECODE     = 3'd2;
    localparam logic [2:0] EXECUTE    = 3'd3;
    localparam logic [2:0] MEM_REQ    = 3'd4;
    localparam logic [2:0] MEM_WAIT   = 3'd5;
    localparam logic [2:0] WRITEBACK  = 3'd6;
    localparam logic [2:0] HALT       = 3'd7;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic            halted_q, halted_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic            next_pc_misaligned;

    // Next-PC selection; only consumed in WRITEBACK.
    always_comb begin
        pc_plus4 = pc_q + XLEN'(4);
        next_pc  = pc_plus4;
        case (opcode)
            OPC_JAL:    next_pc = target_pc;
            OPC_JALR:   next_pc = {target_pc[XLEN-1:1], 1'b0};
            OPC_BRANCH: next_pc = branch_taken ? target_pc : pc_plus4;
            default:    next_pc = pc_plus4;
        endcase
        next_pc_misaligned = |next_pc[1:0];
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        halted_d       = halted_q;
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_req_we    = 1'b0;
        rf_we          = 1'b0;
        wb_sel         = WB_ALU;
        retire         = 1'b0;

        case (state_q)
            FETCH_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    instr_d = imem_resp_data;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXECUTE;
            EXECUTE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = MEM_REQ;
                    OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC,
                    OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_MISC_MEM: state_d = WRITEBACK;
                    default: begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end
                endcase
            end
            MEM_REQ: begin
                dmem_req_valid = 1'b1;
                dmem_req_we    = (opcode == OPC_STORE);
                if (dmem_req_ready) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (dmem_resp_valid) state_d = WRITEBACK;
            end
            WRITEBACK: begin
                case (opcode)
                    OPC_LOAD:           wb_sel = WB_MEM;
                    OPC_JAL, OPC_JALR:  wb_sel = WB_PC4;
                    default:            wb_sel = WB_ALU;
                endcase
                // A misaligned target halts without committing anything.
                if (next_pc_misaligned) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    rf_we   = !(opcode == OPC_STORE || opcode == OPC_BRANCH ||
                                opcode == OPC_MISC_MEM);
                    retire  = 1'b1;
                    pc_d    = next_pc;
                    state_d = FETCH_REQ;
                end
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase

        // Strobes stay quiet for the whole reset assertion.
        if (!reset_n) begin
            imem_req_valid = 1'b0;
            dmem_req_valid = 1'b0;
            dmem_req_we    = 1'b0;
            rf_we          = 1'b0;
            wb_sel         = WB_ALU;
            retire         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= FETCH_REQ;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req_addr = pc_q;
    assign pc            = pc_q;
    assign instr_bits    = instr_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_hart_sequencer.sv
// Directed bench for hart_sequencer: drives imem/dmem handshakes per cycle and checks
// latency, strobes, writeback select, next PC, halt behaviour and reset recovery.
module tb_hart_sequencer;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] instr_bits;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic [31:0] target_pc;
    logic        dmem_req_valid;
    logic        dmem_req_we;
    logic        dmem_req_ready;
    logic        dmem_resp_valid;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [31:0] pc;
    logic        retire;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-instruction observations.
    int          r_cycles, r_we, r_ret, r_dvalid, r_resp_cyc, r_we_cyc;
    logic [1:0]  r_wbsel;
    logic        r_dwe, r_halt, r_done, r_aborted, r_quiet;

    hart_sequencer #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_bits      (instr_bits),
        .opcode          (opcode),
        .branch_taken    (branch_taken),
        .target_pc       (target_pc),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_resp_valid (dmem_resp_valid),
        .rf_we           (rf_we),
        .wb_sel          (wb_sel),
        .pc              (pc),
        .retire          (retire),
        .halted          (halted)
    );

    // Stand-in for the instruction decoder.
    assign opcode = instr_bits[6:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one instruction from FETCH_REQ; imem always ready with a one-cycle response,
    // dmem ready after dstall cycles with a one-cycle response.
    task automatic run_instr(input logic [31:0] instr, input int dstall, input logic bt,
                             input logic [31:0] tgt, input logic abort_mw);
        logic iacc, dacc, iacc_n, dacc_n, ret_now;
        int   ds;
        iacc = 1'b0; dacc = 1'b0; ds = dstall;
        r_cycles = 0; r_we = 0; r_ret = 0; r_dvalid = 0; r_resp_cyc = 0; r_we_cyc = 0;
        r_wbsel = 2'd3; r_dwe = 1'b0; r_halt = 1'b0; r_done = 1'b0;
        r_aborted = 1'b0; r_quiet = 1'b0;
        branch_taken = bt;
        target_pc    = tgt;
        for (int c = 1; c <= 40 && !r_done; c++) begin
            if (halted) begin
                r_halt = 1'b1;
                r_done = 1'b1;
            end else if (abort_mw && dacc) begin
                dmem_resp_valid = 1'b0;
                dmem_req_ready  = 1'b0;
                reset_n = 1'b0;
                tick;
                r_quiet = !(imem_req_valid | dmem_req_valid | dmem_req_we | rf_we | retire)
                          && (wb_sel == 2'd0);
                if (rf_we) r_we++;
                if (retire) r_ret++;
                reset_n   = 1'b1;
                #1;
                r_aborted = 1'b1;
                r_done    = 1'b1;
            end else begin
                r_cycles        = c;
                imem_resp_valid = iacc;
                imem_resp_data  = iacc ? instr : 32'hDEAD_BEEF;
                imem_req_ready  = imem_req_valid;
                iacc_n          = imem_req_valid;
                dmem_resp_valid = dacc;
                if (dacc) r_resp_cyc = c;
                if (dmem_req_valid) begin
                    r_dvalid++;
                    if (dmem_req_we) r_dwe = 1'b1;
                    dmem_req_ready = (ds == 0);
                    if (ds > 0) ds--;
                end else begin
                    dmem_req_ready = 1'b0;
                end
                dacc_n = dmem_req_valid && dmem_req_ready;
                if (rf_we) begin
                    r_we++;
                    r_we_cyc = c;
                end
                ret_now = retire;
                if (retire) begin
                    r_ret++;
                    r_wbsel = wb_sel;
                end
                tick;
                iacc = iacc_n;
                dacc = dacc_n;
                if (ret_now) r_done = 1'b1;
            end
        end
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        check("instr_completes_in_budget", 32'(r_done), 32'd1);
    endtask

    task automatic pulse_reset;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
        branch_taken = 1'b0; target_pc = '0;
        repeat (2) tick;

        check("rst_pc",       pc, 32'h100);
        check("rst_instr",    instr_bits, 32'h0);
        check("rst_halted",   32'(halted), 32'd0);
        check("rst_imem_vld", 32'(imem_req_valid), 32'd0);
        check("rst_dmem_vld", 32'(dmem_req_valid), 32'd0);
        check("rst_dmem_we",  32'(dmem_req_we), 32'd0);
        check("rst_rf_we",    32'(rf_we), 32'd0);
        check("rst_retire",   32'(retire), 32'd0);
        check("rst_wb_sel",   32'(wb_sel), 32'd0);
        reset_n = 1'b1;
        #1;
        check("first_fetch_vld",  32'(imem_req_valid), 32'd1);
        check("first_fetch_addr", imem_req_addr, 32'h100);

        // addi x1,x0,5
        run_instr(32'h0050_0093, 0, 1'b0, 32'h0, 1'b0);
        check("addi_cycles", 32'(r_cycles), 32'd5);
        check("addi_rf_we",  32'(r_we), 32'd1);
        check("addi_retire", 32'(r_ret), 32'd1);
        check("addi_we_cyc", 32'(r_we_cyc), 32'd5);
        check("addi_wb_sel", 32'(r_wbsel), 32'd0);
        check("addi_next",   imem_req_addr, 32'h104);

        // lw x2,0(x0) with dmem ready held low 3 cycles
        run_instr(32'h0000_2103, 3, 1'b0, 32'h0, 1'b0);
        check("lw_cycles",   32'(r_cycles), 32'd10);
        check("lw_dvalid",   32'(r_dvalid), 32'd4);
        check("lw_dmem_we",  32'(r_dwe), 32'd0);
        check("lw_rf_we",    32'(r_we), 32'd1);
        check("lw_wb_sel",   32'(r_wbsel), 32'd1);
        check("lw_we_delay", 32'(r_we_cyc - r_resp_cyc), 32'd1);
        check("lw_next",     pc, 32'h108);

        // sw x2,4(x0)
        run_instr(32'h0020_2223, 0, 1'b0, 32'h0, 1'b0);
        check("sw_cycles",  32'(r_cycles), 32'd7);
        check("sw_dmem_we", 32'(r_dwe), 32'd1);
        check("sw_rf_we",   32'(r_we), 32'd0);
        check("sw_retire",  32'(r_ret), 32'd1);
        check("sw_next",    pc, 32'h10C);

        // beq taken to 0x200
        run_instr(32'h0000_0063, 0, 1'b1, 32'h200, 1'b0);
        check("beq_rf_we",  32'(r_we), 32'd0);
        check("beq_retire", 32'(r_ret), 32'd1);
        check("beq_next",   pc, 32'h200);

        // jalr x1,0(x5) with odd target
        run_instr(32'h0002_80E7, 0, 1'b0, 32'h305, 1'b0);
        check("jalr_wb_sel", 32'(r_wbsel), 32'd2);
        check("jalr_rf_we",  32'(r_we), 32'd1);
        check("jalr_next",   pc, 32'h304);

        // fence: retires, no register write
        run_instr(32'h0000_000F, 0, 1'b0, 32'h0, 1'b0);
        check("fence_rf_we",  32'(r_we), 32'd0);
        check("fence_retire", 32'(r_ret), 32'd1);
        check("fence_next",   pc, 32'h308);

        // ecall halts
        run_instr(32'h0000_0073, 0, 1'b0, 32'h0, 1'b0);
        check("ecall_halt",   32'(r_halt), 32'd1);
        check("ecall_cycles", 32'(r_cycles), 32'd4);
        check("ecall_retire", 32'(r_ret), 32'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid || rf_we || retire) cnt++;
            tick;
        end
        check("halt_quiet",  32'(cnt), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_pc",     pc, 32'h308);
        pulse_reset;
        check("halt_rst_pc",     pc, 32'h100);
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_fetch",  32'(imem_req_valid), 32'd1);

        // jal to misaligned target halts without retiring
        run_instr(32'h0000_006F, 0, 1'b0, 32'h102, 1'b0);
        check("jalmis_halt",   32'(r_halt), 32'd1);
        check("jalmis_retire", 32'(r_ret), 32'd0);
        check("jalmis_rf_we",  32'(r_we), 32'd0);
        check("jalmis_pc",     pc, 32'h100);
        pulse_reset;

        // jal x1 to top word, then addi wraps PC to 0
        run_instr(32'h0000_00EF, 0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        check("jal_wb_sel", 32'(r_wbsel), 32'd2);
        check("jal_next",   pc, 32'hFFFF_FFFC);
        run_instr(32'h0050_0093, 0, 1'b0, 32'h0, 1'b0);
        check("wrap_retire", 32'(r_ret), 32'd1);
        check("wrap_addr",   imem_req_addr, 32'h0);

        // reset while waiting for load data
        run_instr(32'h0000_2103, 0, 1'b0, 32'h0, 1'b1);
        check("abort_taken",  32'(r_aborted), 32'd1);
        check("abort_rf_we",  32'(r_we), 32'd0);
        check("abort_retire", 32'(r_ret), 32'd0);
        check("abort_quiet",  32'(r_quiet), 32'd1);
        check("abort_pc",     pc, 32'h100);
        check("abort_fetch",  32'(imem_req_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hart_sequencer.md
# hart_sequencer

Multi-cycle control FSM for the RV32I hart. Fetches one instruction at a time over a valid/ready instruction-memory port and holds it in an instruction register feeding the instruction decoder. It steps the instruction through decode, execute, optional data-memory access and writeback. It owns the program counter, register-file write enable, writeback select and retire/halt status; datapath arithmetic (ALU, branch compare, target address) is external.

## Interface
- `XLEN`, 32: data/address width.
- `ILEN`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.

- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_addr`  out  XLEN  fetch address (= `pc`).
- `imem_req_ready`  in  1  fetch request accepted this cycle.
- `imem_resp_valid`  in  1  fetch data valid.
- `imem_resp_data`  in  ILEN  fetched instruction.
- `instr_bits`  out  ILEN  instruction register, to decoder.
- `opcode`  in  7  decoded opcode (`instr_bits[6:0]`) from decoder.
- `branch_taken`  in  1  branch comparison result from datapath.
- `target_pc`  in  XLEN  JAL/JALR/branch target from datapath.
- `dmem_req_valid`  out  1  data request.
- `dmem_req_we`  out  1  1 = store, 0 = load.
- `dmem_req_ready`  in  1  data request accepted.
- `dmem_resp_valid`  in  1  load data / store acknowledge.
- `rf_we`  out  1  register-file write strobe.
- `wb_sel`  out  2  0 = ALU, 1 = memory, 2 = pc+4.
- `pc`  out  XLEN  current PC.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `halted`  out  1  sticky; set on illegal opcode or misaligned target.

## Operation
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, HALT.
- **FETCH_REQ**
  - `imem_req_valid=1`.
  - Goes to FETCH_WAIT on `imem_req_ready`; otherwise holds. Address held stable while waiting.
- **FETCH_WAIT**
  - On `imem_resp_valid`, `instr_bits <= imem_resp_data` and go to DECODE.
- **DECODE**
  - Single settle cycle for the decoder and register-file read. Always goes to EXECUTE.
- **EXECUTE**, on `opcode`:
  - LOAD 0000011, STORE 0100011: go to MEM_REQ.
  - OP-IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, MISC-MEM 0001111 (no-op): go to WRITEBACK.
  - Any other value, including SYSTEM: go to HALT.
- **MEM_REQ**
  - `dmem_req_valid=1`; `dmem_req_we=1` for STORE.
  - Goes to MEM_WAIT on `dmem_req_ready`.
- **MEM_WAIT**
  - Goes to WRITEBACK on `dmem_resp_valid`.
- **WRITEBACK**
  - `rf_we=1` for all classes except STORE, BRANCH and MISC-MEM. Writes to x0 are discarded by the register file, not here.
  - `wb_sel`: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - Next PC:
    - JAL, or BRANCH with `branch_taken`: `target_pc`.
    - JALR: `{target_pc[XLEN-1:1],1'b0}`.
    - Otherwise: `pc+4`, modulo 2^XLEN (wraps at 32'hFFFF_FFFC to 0).
  - If the selected next PC has `[1:0]!=0`: go to HALT. PC, `rf_we` and `retire` are unaffected.
  - Otherwise: PC updates, `retire=1`, go to FETCH_REQ.
- **HALT**
  - Absorbing state. `halted=1`, all request valids 0, `rf_we=0`. Exits only by reset.
- Responses arriving outside their wait state (e.g. `imem_resp_valid` in FETCH_REQ) are ignored.

## Timing
- Reset (`reset_n=0` sampled at a clock edge):
  - `pc=RESET_PC`, `instr_bits=0`, state FETCH_REQ, `halted=0`.
  - While `reset_n=0`, all of `imem_req_valid`, `dmem_req_valid`, `dmem_req_we`, `rf_we`, `retire` and `wb_sel` are 0 (combinational outputs are gated by `reset_n`).
- A mid-instruction reset abandons the instruction with no writeback and no retire. Both memories share `reset_n`, so no stale responses remain.
- `pc`, `instr_bits` and `halted` are registered. Valids, `rf_we`, `wb_sel` and `retire` are decoded from the state register. No combinational path runs from a `*_ready` or `*_valid` input to any output.
- Minimum latency with ready=1 and the response one cycle after acceptance:
  - Non-memory instruction: 5 cycles, FETCH_REQ through WRITEBACK.
  - Load/store: 7 cycles.
  - Each ready or response stall cycle adds exactly 1 cycle.
- `rf_we` and `retire` are asserted for exactly one cycle per instruction, in the same cycle as each other. The new `pc` is visible the cycle after WRITEBACK.
- `instr_bits` is stable from DECODE through WRITEBACK.

## Test plan
- Reset with `RESET_PC=32'h100`, ready=1, one-cycle response `addi x1,x0,5` (32'h00500093): `imem_req_addr=0x100`; `rf_we` and `retire` high in cycle 5 with `wb_sel=0`; next fetch at 0x104.
- `lw` with `dmem_req_ready` low for 3 cycles: `dmem_req_valid` held for 4 cycles; `rf_we=1`, `wb_sel=1` one cycle after `dmem_resp_valid`; total 10 cycles.
- `sw`, then `beq` taken with `target_pc=0x200`, then `jalr` with `target_pc=0x305`:
  - `sw`: `rf_we=0`, `dmem_req_we=1`.
  - `beq`: `rf_we=0`, next `pc=0x200`.
  - `jalr`: `wb_sel=2`, next `pc=0x304`.
- Opcode 1110011 (ecall): HALT entered after EXECUTE; `halted=1`; no further `imem_req_valid` for 20 cycles; `reset_n` low for one cycle returns to FETCH_REQ at `RESET_PC`.
- JAL with `target_pc=0x102`: `halted=1`, `retire=0`, `pc` unchanged. Separately, PC 32'hFFFF_FFFC with `addi` wraps to next fetch at 0.
- `reset_n` dropped while in MEM_WAIT: no `rf_we`/`retire`; valids 0 during reset; fetch at `RESET_PC` after release.
